poly_sweep_ctrl: RTL and testbench
==================================

POLY_SWEEP_CTRL -- requirements
Module: poly_sweep_ctrl

Interface
REQ-001 Parameter: LATENCY, default 3, cycles from a start_out/x_out/c_out issue to the matching result_in (range 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 go  input  1  request one sweep; sampled in IDLE only.
REQ-005 coef  input  2  constant term for the sweep; latched on go acceptance.
REQ-006 x_out  output  2  x operand driven to the polynomial pipeline.
REQ-007 c_out  output  2  constant operand driven to the polynomial pipeline.
REQ-008 start_out  output  1  issue strobe to the pipeline; x_out/c_out valid while high.
REQ-009 result_in  input  6  pipeline result, valid LATENCY cycles after its issue.
REQ-010 busy  output  1  high from go acceptance until leaving DONE.
REQ-011 done  output  1  one-cycle pulse when all four results are captured.
REQ-012 rd_addr  input  2  result buffer read index (x value).
REQ-013 rd_data  output  6  buffer[rd_addr], combinational read.
REQ-014 max_val  output  6  largest captured result of the last sweep.
REQ-015 max_x  output  2  x that produced max_val.

Function
REQ-016 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on go=1; ISSUE->DRAIN after x=3 issued; DRAIN->DONE on capture of x=3; DONE->IDLE unconditionally next edge.
REQ-017 On go acceptance at edge k: latch coef into c_out, clear max_val/max_x to 0, drive start_out=1, x_out=0 after edge k.
REQ-018 ISSUE: start_out=1 for exactly 4 consecutive cycles with x_out = 0,1,2,3; start_out=0 and x_out=0 after edge k+4.
REQ-019 c_out holds the latched coef from edge k until the next accepted go.
REQ-020 Issue tracking: LATENCY-deep shift register of {valid, x tag} loaded from {start_out, x_out} every edge; no dependence on external handshake.
REQ-021 Capture: when tracker tail is valid, result_in is written to buffer[tag] at that edge; x=n captured at edge k+LATENCY+1+n.
REQ-022 Max update at each capture: replace if result_in > max_val (strict); ties keep the lower x; first capture (x=0) always loads.
REQ-023 done=1 for exactly the cycle after edge k+LATENCY+4 (state DONE); busy falls after edge k+LATENCY+5.
REQ-024 go while busy=1 is ignored; go held high in IDLE after DONE starts a new sweep immediately.
REQ-025 Buffer and max outputs hold their values after DONE until overwritten by the next sweep.
REQ-026 All arithmetic 6-bit unsigned; no saturation, no wrap handling required in this block.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, x_out=0, c_out=0, start_out=0, busy=0, done=0, max_val=0, max_x=0, tracker cleared, buffer all 0.
REQ-028 Reset mid-sweep aborts; results in flight at reset are never captured after release.
REQ-029 First go is accepted on the first rising edge with rst_n=1 and go=1.

Verification
REQ-030 Bench uses behavioural pipe model, result = x^3 + c, latency LATENCY=3.
REQ-031 go pulse, coef=1 -> x_out 0,1,2,3 on 4 cycles, c_out=1; buffer = 1,2,9,28; max_val=28, max_x=3; done at go-edge+7.
REQ-032 go held high across sweep -> exactly one sweep until DONE, then second sweep starts at IDLE edge; done pulses once per sweep.
REQ-033 rst_n low for one cycle during DRAIN (after x=1 captured) -> all outputs 0 immediately; no further captures; buffer reads 0.
REQ-034 Model returning constant 5 for all x -> max_val=5, max_x=0 (tie rule).
REQ-035 Rerun with LATENCY=1 and LATENCY=8 -> done at go-edge+LATENCY+4, buffer contents match REQ-031.

Source files
------------

// File: rtl/poly_sweep_ctrl_if.sv
// Link between the sweep controller and the external polynomial pipeline.
//   start_out : issue strobe; x_out/c_out are valid while it is high
//   x_out     : x operand (0..3)
//   c_out     : constant operand
//   result_in : pipeline result, valid LATENCY cycles after its issue
// master = controller side, slave = pipeline side.
interface poly_sweep_ctrl_if;
  logic       start_out;
  logic [1:0] x_out;
  logic [1:0] c_out;
  logic [5:0] result_in;

  modport master (
    output start_out,
    output x_out,
    output c_out,
    input  result_in
  );

  modport slave (
    input  start_out,
    input  x_out,
    input  c_out,
    output result_in
  );
endinterface

// File: rtl/poly_sweep_ctrl.sv
// Sweep controller. On go it issues x = 0..3 with a latched constant to an external
// fixed-latency polynomial pipeline. It stores the four results in a small buffer
// indexed by x and tracks the largest result and the x that produced it.
//   clk, rst_n : clock, asynchronous active-low reset
//   go, coef   : sweep request (sampled in idle only) and constant term
//   pipe       : pipeline link (start_out, x_out, c_out, result_in)
//   busy, done : sweep in progress, one-cycle completion pulse
//   rd_addr    : buffer read index; rd_data returns that entry combinationally
//   max_val    : largest result of the last sweep; max_x is its x
module poly_sweep_ctrl #(
  parameter int unsigned LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [1:0]               coef,
  poly_sweep_ctrl_if.master        pipe,
  output logic                     busy,
  output logic                     done,
  input  logic [1:0]               rd_addr,
  output logic [5:0]               rd_data,
  output logic [5:0]               max_val,
  output logic [1:0]               max_x
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [1:0]         x_q;
  logic [1:0]         c_q;
  logic [LATENCY-1:0] trk_vld_q;
  logic [1:0]         trk_tag_q [LATENCY];
  logic [5:0]         buf_q [4];
  logic [5:0]         max_val_q;
  logic [1:0]         max_x_q;

  logic       start;
  logic       accept;
  logic       capture;
  logic [1:0] cap_tag;

  assign accept  = (state_q == StIdle) && go;
  // The tracker tail lines up with the cycle the pipeline presents the matching result.
  assign capture = trk_vld_q[LATENCY-1];
  assign cap_tag = trk_tag_q[LATENCY-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StIssue;
      StIssue: if (x_q == 2'd3) state_d = StDrain;
      StDrain: if (capture && (cap_tag == 2'd3)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    start = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  busy  = 1'b0;
      StIssue: start = 1'b1;
      StDrain: ;
      StDone:  done  = 1'b1;
      default: ;
    endcase
  end

  // Operand registers; x wraps back to 0 after the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 2'd0;
      c_q <= 2'd0;
    end else begin
      if (start) x_q <= x_q + 2'd1;
      if (accept) c_q <= coef;
    end
  end

  // Issue tracker: free-running shift of {start, x}, no handshake from the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) trk_tag_q[i] <= 2'd0;
    end else begin
      trk_vld_q[0] <= start;
      trk_tag_q[0] <= x_q;
      for (int i = 1; i < int'(LATENCY); i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_tag_q[i] <= trk_tag_q[i-1];
      end
    end
  end

  // Result buffer and running maximum; strict compare keeps the lower x on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= 6'd0;
      max_val_q <= 6'd0;
      max_x_q   <= 2'd0;
    end else begin
      if (capture) buf_q[cap_tag] <= pipe.result_in;
      if (accept) begin
        max_val_q <= 6'd0;
        max_x_q   <= 2'd0;
      end else if (capture && ((cap_tag == 2'd0) || (pipe.result_in > max_val_q))) begin
        max_val_q <= pipe.result_in;
        max_x_q   <= cap_tag;
      end
    end
  end

  assign pipe.start_out = start;
  assign pipe.x_out     = x_q;
  assign pipe.c_out     = c_q;
  assign rd_data        = buf_q[rd_addr];
  assign max_val        = max_val_q;
  assign max_x          = max_x_q;

endmodule

// File: tb/tb_poly_sweep_ctrl.sv
// Bench for poly_sweep_ctrl: three instances (LATENCY 3, 1, 8) share the same
// stimulus, each with its own behavioural pipeline model (x^3 + c, or constant 5).
module tb_poly_sweep_ctrl;
  localparam int NumDut = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [1:0] coef = 2'd0;
  logic [1:0] rd_addr = 2'd0;
  bit         cubic = 1'b1;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic       busy_w    [NumDut];
  logic       done_w    [NumDut];
  logic       start_w   [NumDut];
  logic [1:0] x_w       [NumDut];
  logic [1:0] c_w       [NumDut];
  logic [5:0] rd_data_w [NumDut];
  logic [5:0] max_val_w [NumDut];
  logic [1:0] max_x_w   [NumDut];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    if (i == 0) return 3;
    if (i == 1) return 1;
    return 8;
  endfunction

  function automatic logic [5:0] ref_res(input logic [1:0] x, input logic [1:0] c, input bit cub);
    int v;
    if (!cub) return 6'd5;
    v = int'(x);
    v = v * v * v + int'(c);
    return 6'(v);
  endfunction

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 3 : (g == 1) ? 1 : 8;
    poly_sweep_ctrl_if pif ();
    logic       h_vld [64];
    logic [1:0] h_x   [64];
    logic [1:0] h_c   [64];
    int         slot;
    int         old_slot;

    poly_sweep_ctrl #(.LATENCY(Lat)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (go),
      .coef    (coef),
      .pipe    (pif),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .rd_addr (rd_addr),
      .rd_data (rd_data_w[g]),
      .max_val (max_val_w[g]),
      .max_x   (max_x_w[g])
    );

    assign start_w[g] = pif.start_out;
    assign x_w[g]     = pif.x_out;
    assign c_w[g]     = pif.c_out;

    initial begin
      for (int i = 0; i < 64; i++) h_vld[i] = 1'b0;
      pif.result_in = 6'd0;
    end

    // Pipeline model: what was issued in cycle n is presented in cycle n+Lat.
    always @(negedge clk) begin
      slot        = cyc % 64;
      h_vld[slot] = pif.start_out;
      h_x[slot]   = pif.x_out;
      h_c[slot]   = pif.c_out;
      old_slot    = (cyc - int'(Lat)) % 64;
      if (cyc >= int'(Lat) && h_vld[old_slot])
        pif.result_in = ref_res(h_x[old_slot], h_c[old_slot], cubic);
      else
        pif.result_in = 6'($urandom);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NumDut; i++) begin
      check($sformatf("%s start[%0d]", tag, i), int'(start_w[i]), 0);
      check($sformatf("%s x[%0d]", tag, i), int'(x_w[i]), 0);
      check($sformatf("%s c[%0d]", tag, i), int'(c_w[i]), 0);
      check($sformatf("%s busy[%0d]", tag, i), int'(busy_w[i]), 0);
      check($sformatf("%s done[%0d]", tag, i), int'(done_w[i]), 0);
      check($sformatf("%s max_val[%0d]", tag, i), int'(max_val_w[i]), 0);
      check($sformatf("%s max_x[%0d]", tag, i), int'(max_x_w[i]), 0);
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      for (int i = 0; i < NumDut; i++)
        check($sformatf("%s buf%0d[%0d]", tag, a, i), int'(rd_data_w[i]), 0);
    end
  endtask

  // Call at a negedge with every instance idle; returns at the negedge after acceptance.
  task automatic start_go(input logic [1:0] c, input bit hold_go, output int k);
    go   = 1'b1;
    coef = c;
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    if (!hold_go) go = 1'b0;
  endtask

  task automatic watch_sweep(input int k, input logic [1:0] c, input bit hold_go);
    int off;
    int lat;
    for (int n = 0; n <= 14; n++) begin
      if (n > 0) @(negedge clk);
      off = cyc - k;
      for (int i = 0; i < NumDut; i++) begin
        lat = lat_of(i);
        if (off <= lat + 5) begin
          check($sformatf("start[%0d]@%0d", i, off), int'(start_w[i]), (off < 4) ? 1 : 0);
          check($sformatf("x[%0d]@%0d", i, off), int'(x_w[i]), (off < 4) ? off : 0);
          check($sformatf("c[%0d]@%0d", i, off), int'(c_w[i]), int'(c));
          check($sformatf("busy[%0d]@%0d", i, off), int'(busy_w[i]), (off <= lat + 4) ? 1 : 0);
          check($sformatf("done[%0d]@%0d", i, off), int'(done_w[i]), (off == lat + 4) ? 1 : 0);
        end else if (off == lat + 6) begin
          // Held go restarts straight from idle; a released go leaves it idle.
          check($sformatf("restart busy[%0d]", i), int'(busy_w[i]), hold_go ? 1 : 0);
          check($sformatf("restart start[%0d]", i), int'(start_w[i]), hold_go ? 1 : 0);
          check($sformatf("restart x[%0d]", i), int'(x_w[i]), 0);
        end
      end
    end
    go = 1'b0;
  endtask

  task automatic wait_idle();
    bit all_idle;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      all_idle = 1'b1;
      for (int i = 0; i < NumDut; i++) if (busy_w[i]) all_idle = 1'b0;
      if (all_idle) break;
    end
    for (int i = 0; i < NumDut; i++) check($sformatf("idle busy[%0d]", i), int'(busy_w[i]), 0);
  endtask

  task automatic check_results(input logic [1:0] c, input bit cub);
    logic [5:0] exp_buf [4];
    logic [5:0] mv;
    int         mx;
    for (int x = 0; x < 4; x++) exp_buf[x] = ref_res(2'(x), c, cub);
    mv = exp_buf[0];
    mx = 0;
    for (int x = 1; x < 4; x++) if (exp_buf[x] > mv) begin
      mv = exp_buf[x];
      mx = x;
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      for (int i = 0; i < NumDut; i++)
        check($sformatf("buf%0d[%0d] c=%0d", a, i, c), int'(rd_data_w[i]), int'(exp_buf[a]));
    end
    for (int i = 0; i < NumDut; i++) begin
      check($sformatf("max_val[%0d] c=%0d", i, c), int'(max_val_w[i]), int'(mv));
      check($sformatf("max_x[%0d] c=%0d", i, c), int'(max_x_w[i]), mx);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         k;
    logic [1:0] c;
    bit         hold_go;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // First go accepted on the first edge after release; coef=1 gives 1,2,9,28
    @(negedge clk);
    rst_n = 1'b1;
    cubic = 1'b1;
    start_go(2'd1, 1'b0, k);
    watch_sweep(k, 2'd1, 1'b0);
    wait_idle();
    check_results(2'd1, 1'b1);

    // Constant pipeline output: tie keeps x=0
    @(negedge clk);
    cubic = 1'b0;
    start_go(2'd2, 1'b0, k);
    watch_sweep(k, 2'd2, 1'b0);
    wait_idle();
    check_results(2'd2, 1'b0);

    // go held through the sweep
    @(negedge clk);
    cubic = 1'b1;
    start_go(2'd3, 1'b1, k);
    watch_sweep(k, 2'd3, 1'b1);
    wait_idle();
    check_results(2'd3, 1'b1);

    // Randomized sweeps
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(3, 1)) @(negedge clk);
      cubic   = ($urandom_range(3, 0) != 0);
      c       = 2'($urandom);
      hold_go = ($urandom_range(3, 0) == 0);
      start_go(c, hold_go, k);
      watch_sweep(k, c, hold_go);
      wait_idle();
      check_results(c, cubic);
    end

    // Reset in DRAIN just after x=1 is captured by the LATENCY=3 instance
    @(negedge clk);
    cubic = 1'b1;
    start_go(2'd2, 1'b0, k);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_all_zero("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
